// File: rtl/pad_sense.sv
// pad_sense: synchronised, glitch-filtered pad sampler with rise/fall pulses; level follows pad FILTER_LEN+1 edges after s1 loads, no backpressure.
// Define PAD_SENSE_EDGE_CNT_EN to build the saturating edge counter; otherwise edge_cnt is tied to 0 and cnt_clr is ignored.
module pad_sense #(
    parameter int ID         = 0,
    parameter int FILTER_LEN = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire              pad,
    input  logic             cnt_clr,
    output logic             level,
    output logic             valid,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt
);

    localparam int CW = ($clog2(FILTER_LEN + 1) < 1) ? 1 : $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    typedef enum logic {ACQ, TRACK} state_t;

    state_t          state, state_n;
    logic            s1, s2, s3;
    logic [CW-1:0]   cnt, cnt_n;
    logic            level_n, valid_n, rise_n, fall_n;

    // pad is observed only; this block never drives the net
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACQ;
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            valid <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_n;
            s1    <= pad;
            s2    <= s1;
            s3    <= s2;
            cnt   <= cnt_n;
            level <= level_n;
            valid <= valid_n;
            rise  <= rise_n;
            fall  <= fall_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = '0;
        level_n = level;
        valid_n = valid;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            ACQ: begin
                if (s2 == s3) begin
                    if (cnt == LAST) begin
                        level_n = s2;
                        valid_n = 1'b1;
                        state_n = TRACK;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            TRACK: begin
                if (s2 != level) begin
                    if (cnt == LAST) begin
                        level_n = s2;
                        rise_n  = s2;
                        fall_n  = ~s2;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
            end
            default: state_n = ACQ;
        endcase
    end

`ifdef PAD_SENSE_EDGE_CNT_EN
    logic [CNT_W-1:0] ecnt;

    // counts alongside the pulse register so edge_cnt moves in the same cycle as rise/fall
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            ecnt <= '0;
        end else if ((rise_n || fall_n) && (ecnt != {CNT_W{1'b1}})) begin
            ecnt <= ecnt + CNT_W'(1);
        end
    end

    assign edge_cnt = ecnt;
    wire unused_ok = &{1'b0, (ID != 0)};
`else
    assign edge_cnt = '0;
    wire unused_ok = &{1'b0, cnt_clr, (ID != 0)};
`endif

endmodule

// File: tb/tb_pad_sense.sv
// Directed scenarios followed by random pad runs, checked against a sliding-window model of the filter.
module tb_pad_sense;

    localparam int FL    = 4;
    localparam int CNT_W = 2;
`ifdef PAD_SENSE_EDGE_CNT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, cnt_clr, pad_drv;
    wire              pad;
    logic             level, valid, rise, fall;
    logic [CNT_W-1:0] edge_cnt;

    assign pad = pad_drv;

    pad_sense #(.ID(3), .FILTER_LEN(FL), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .pad      (pad),
        .cnt_clr  (cnt_clr),
        .level    (level),
        .valid    (valid),
        .rise     (rise),
        .fall     (fall),
        .edge_cnt (edge_cnt)
    );

    int tests = 0;
    int fails = 0;

    // model: pad history since reset, and the sequence of synchronised samples
    bit padhist[$];
    bit xs[$];
    bit m_level, m_valid, m_rise, m_fall;
    int m_ecnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit p, input bit clr, input bit r);
        bit x, all;
        int n;
        if (r) begin
            padhist.delete();
            xs.delete();
            xs.push_back(1'b0);
            m_level = 0; m_valid = 0; m_rise = 0; m_fall = 0; m_ecnt = 0;
            return;
        end
        padhist.push_back(p);
        x = (padhist.size() >= 3) ? padhist[padhist.size() - 3] : 1'b0;
        xs.push_back(x);
        n = xs.size();
        m_rise = 0;
        m_fall = 0;
        if (!m_valid) begin
            // acquire once the last FL+1 samples agree
            if (n >= FL + 1) begin
                all = 1;
                for (int i = n - FL - 1; i < n; i++) if (xs[i] != x) all = 0;
                if (all) begin
                    m_level = x;
                    m_valid = 1;
                end
            end
        end else begin
            // follow once the last FL samples all disagree with level
            all = 1;
            for (int i = n - FL; i < n; i++) if (xs[i] == m_level) all = 0;
            if (all) begin
                m_rise  = x;
                m_fall  = !x;
                m_level = x;
            end
        end
        if (!EN || clr) m_ecnt = 0;
        else if ((m_rise || m_fall) && m_ecnt < (1 << CNT_W) - 1) m_ecnt++;
    endtask

    task automatic step(input bit p, input bit clr, input bit r);
        pad_drv = p;
        cnt_clr = clr;
        rst     = r;
        @(posedge clk);
        model_edge(p, clr, r);
        #1;
        check("level",    32'(level),    32'(m_level));
        check("valid",    32'(valid),    32'(m_valid));
        check("rise",     32'(rise),     32'(m_rise));
        check("fall",     32'(fall),     32'(m_fall));
        check("edge_cnt", 32'(edge_cnt), 32'(m_ecnt));
        check("rise_and_fall", 32'(rise & fall), 32'd0);
    endtask

    initial begin
        bit seen;
        bit p;
        int run;
        rst = 1'b1; cnt_clr = 1'b0; pad_drv = 1'b0;

        step(0, 0, 1);
        step(0, 0, 1);
        check("reset_level", 32'(level), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_ecnt",  32'(edge_cnt), 32'd0);

        // acquisition with pad held high
        for (int j = 1; j <= 7; j++) begin
            step(1, 0, 0);
            if (j == 6) check("s1_valid_e6", 32'(valid), 32'd0);
            if (j == 7) begin
                check("s1_valid_e7", 32'(valid), 32'd1);
                check("s1_level_e7", 32'(level), 32'd1);
            end
        end

        // acquire low, then a 3-sample glitch
        step(0, 0, 1);
        for (int j = 0; j < 8; j++) step(0, 0, 0);
        check("s2_acq_valid", 32'(valid), 32'd1);
        seen = 0;
        for (int j = 0; j < 3; j++) begin step(1, 0, 0); seen |= rise; end
        for (int j = 0; j < 6; j++) begin step(0, 0, 0); seen |= rise; end
        check("s2_no_rise",  32'(seen), 32'd0);
        check("s2_level",    32'(level), 32'd0);
        check("s2_ecnt",     32'(edge_cnt), 32'd0);

        // clean rise
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0);
            if (i == 4) check("s3_level_e4", 32'(level), 32'd0);
            if (i == 5) begin
                check("s3_level_e5", 32'(level), 32'd1);
                check("s3_rise_e5",  32'(rise), 32'd1);
                check("s3_ecnt",     32'(edge_cnt), EN ? 32'd1 : 32'd0);
            end
            if (i == 6) check("s3_rise_e6", 32'(rise), 32'd0);
        end

        // saturation, then clear on the rise edge
        p = 1;
        for (int t = 0; t < 5; t++) begin
            p = !p;
            for (int i = 0; i < 8; i++) step(p, 0, 0);
        end
        check("s4_sat", 32'(edge_cnt), EN ? 32'd3 : 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1, (i == 5), 0);
            if (i == 5) begin
                check("s4_clr_rise", 32'(rise), 32'd1);
                check("s4_clr_ecnt", 32'(edge_cnt), 32'd0);
            end
        end

        // reset while tracking high
        step(1, 0, 1);
        check("s5_level", 32'(level), 32'd0);
        check("s5_valid", 32'(valid), 32'd0);
        check("s5_fall",  32'(fall), 32'd0);
        check("s5_ecnt",  32'(edge_cnt), 32'd0);
        step(1, 0, 0);
        check("s5_fall_next", 32'(fall), 32'd0);

        // random runs of pad levels with occasional clears and resets
        p = 0;
        run = 0;
        for (int c = 0; c < 1500; c++) begin
            if (run == 0) begin
                p = !p;
                run = $urandom_range(1, 7);
            end
            run--;
            step(p, ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pad_sense.md
PAD_SENSE -- requirements
Module: pad_sense

Interface
REQ-001 Parameter ID, default 0: pad instance identifier; no functional effect.
REQ-002 Parameter FILTER_LEN, default 4: consecutive stable samples required before accepting a level; legal range 1..255.
REQ-003 Parameter CNT_W, default 8: width of edge_cnt; legal range 1..16.
REQ-004 clk  input  1  sole clock; all flops update on the rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 pad  inout  1  pad net; sampled only and never driven (block drives high-Z).
REQ-007 cnt_clr  input  1  synchronous clear of edge_cnt.
REQ-008 level  output  1  filtered pad level.
REQ-009 valid  output  1  level has been acquired since reset.
REQ-010 rise  output  1  one-cycle pulse on a filtered 0->1 transition.
REQ-011 fall  output  1  one-cycle pulse on a filtered 1->0 transition.
REQ-012 edge_cnt  output  CNT_W  saturating count of rise and fall pulses.

Function
REQ-013 pad SHALL pass through a 2-flop synchronizer (s1, then s2); s3 SHALL hold the previous s2.
REQ-014 The FSM SHALL have exactly two states: ACQ (reset state) and TRACK.
REQ-015 ACQ: if s2==s3, cnt SHALL increment, else clear to 0. When cnt==FILTER_LEN-1 and s2==s3: level<=s2, valid<=1, cnt<=0, go to TRACK, no rise/fall pulse.
REQ-016 TRACK: if s2!=level, cnt SHALL increment, else clear to 0. When cnt==FILTER_LEN-1 and s2!=level: level<=s2, cnt<=0, and rise or fall SHALL pulse on the same edge.
REQ-017 Latency in TRACK: level SHALL change on the (FILTER_LEN+1)th rising edge after the edge that first loads the new value into s1.
REQ-018 A pad excursion that holds for fewer than FILTER_LEN s2 samples SHALL produce no level change and no pulse.
REQ-019 rise and fall SHALL be registered, never high together, and high for exactly one cycle per transition.
REQ-020 edge_cnt SHALL increment by 1 on each rise or fall pulse and saturate at 2^CNT_W-1.
REQ-021 If cnt_clr is high on an edge, edge_cnt SHALL become 0 and an increment on that same edge SHALL be dropped.
REQ-022 cnt SHALL be ceil(log2(FILTER_LEN+1)) bits wide (minimum 1) and SHALL never exceed FILTER_LEN-1.

Reset
REQ-023 When rst is high on an edge: state=ACQ; s1=s2=s3=0; cnt=0; level=0; valid=0; rise=fall=0; edge_cnt=0.
REQ-024 Reset mid-operation SHALL abort immediately: no pulse on the reset edge or on the following edge, and reacquisition starts from ACQ.

Configuration
REQ-025 Macro PAD_SENSE_EDGE_CNT_EN defined: the edge_cnt counter is built per REQ-020/021.
REQ-026 Macro undefined: edge_cnt is tied to 0, cnt_clr is ignored, and no counter flops exist. All other behaviour is identical.

Verification (FILTER_LEN=4, macro defined unless stated)
REQ-027 Scenario 1: pad=1 held, rst released -> valid=1 and level=1 after the 7th rising edge following deassertion; rise=fall=0 throughout.
REQ-028 Scenario 2: TRACK with level=0, pad high for 3 cycles then low -> level stays 0, no rise, edge_cnt unchanged.
REQ-029 Scenario 3: TRACK with level=0, pad 0->1 held -> level=1 on the 5th edge after s1 samples 1; rise high for exactly that one cycle; edge_cnt=1.
REQ-030 Scenario 4: CNT_W=2, 5 filtered toggles -> edge_cnt=3 (saturated); cnt_clr asserted on the edge of a rise pulse -> edge_cnt=0.
REQ-031 Scenario 5: TRACK with level=1, rst held for 1 cycle -> level=0, valid=0, edge_cnt=0 after that edge; no fall pulse.
REQ-032 Scenario 6: macro undefined, 10 toggles plus cnt_clr pulses -> edge_cnt=0 always; level, rise and fall as in Scenario 3.
